// File: rtl/ap_mon_pkg.sv
// Shared types for the ap_ctrl performance monitor: channel/top state enums,
// per-channel statistics record and saturating counter helpers.
package ap_mon_pkg;

    // Stats fields are stored at the widest supported width; CNT_W selects the live bits.
    localparam int unsigned MAX_CNT_W = 64;

    typedef logic [MAX_CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_BUSY,
        CH_DONE_WAIT
    } ch_state_e;

    typedef enum logic [1:0] {
        TOP_MON,
        TOP_DUMP,
        TOP_END
    } top_state_e;

    typedef struct packed {
        cnt_t count;
        cnt_t lat_last;
        cnt_t lat_min;
        cnt_t lat_max;
        cnt_t stall;
    } ch_stats_t;

    function automatic cnt_t cnt_max(int unsigned w);
        return {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
    endfunction

    function automatic cnt_t sat_inc(cnt_t v, int unsigned w);
        return (v >= cnt_max(w)) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/ap_ch_tracker.sv
// One ap_ctrl channel: IDLE/BUSY/DONE_WAIT tracking, latency timer and
// saturating completion/stall statistics. Holds all state while frozen.
module ap_ch_tracker
    import ap_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      freeze_i,
    input  logic      ap_start_i,
    input  logic      ap_done_i,
    input  logic      ap_continue_i,
    output ch_stats_t stats_o,
    output logic      busy_o
);

    ch_state_e state_q;
    cnt_t      timer_q;
    ch_stats_t stats_q;
    logic      complete_d;
    logic      stall_d;

    always_comb begin
        complete_d = 1'b0;
        stall_d    = 1'b0;
        case (state_q)
            CH_BUSY: begin
                complete_d = ap_done_i && ap_continue_i;
                stall_d    = ap_done_i && !ap_continue_i;
            end
            CH_DONE_WAIT: begin
                complete_d = ap_continue_i;
                stall_d    = ap_done_i && !ap_continue_i;
            end
            default: ;
        endcase
    end

    // timer_q counts cycles since the start cycle, so it equals the latency on the completing cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= CH_IDLE;
            timer_q          <= '0;
            stats_q.count    <= '0;
            stats_q.lat_last <= '0;
            stats_q.lat_min  <= cnt_max(CNT_W);
            stats_q.lat_max  <= '0;
            stats_q.stall    <= '0;
        end else if (!freeze_i) begin
            if (stall_d) begin
                stats_q.stall <= sat_inc(stats_q.stall, CNT_W);
            end
            if (complete_d) begin
                stats_q.count    <= sat_inc(stats_q.count, CNT_W);
                stats_q.lat_last <= timer_q;
                if (timer_q < stats_q.lat_min) stats_q.lat_min <= timer_q;
                if (timer_q > stats_q.lat_max) stats_q.lat_max <= timer_q;
            end
            case (state_q)
                CH_IDLE: begin
                    if (ap_start_i) begin
                        state_q <= CH_BUSY;
                        timer_q <= cnt_t'(1);
                    end
                end
                CH_BUSY, CH_DONE_WAIT: begin
                    if (complete_d) begin
                        if (ap_start_i) begin
                            state_q <= CH_BUSY;
                            timer_q <= cnt_t'(1);
                        end else begin
                            state_q <= CH_IDLE;
                            timer_q <= '0;
                        end
                    end else begin
                        if (stall_d) state_q <= CH_DONE_WAIT;
                        timer_q <= sat_inc(timer_q, CNT_W);
                    end
                end
                default: state_q <= CH_IDLE;
            endcase
        end
    end

    assign stats_o = stats_q;
    assign busy_o  = (state_q != CH_IDLE);

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor: trackers run until finish, then
// one record per channel is dumped over a valid/ready handshake.
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ap_start,
    input  logic [NUM_CH-1:0]       ap_ready,
    input  logic [NUM_CH-1:0]       ap_done,
    input  logic [NUM_CH-1:0]       ap_continue,
    input  logic                    finish,
    input  logic                    rec_ready,
    output logic                    rec_valid,
    output logic [$clog2(NUM_CH):0] rec_ch,
    output logic [CNT_W-1:0]        rec_count,
    output logic [CNT_W-1:0]        rec_lat_last,
    output logic [CNT_W-1:0]        rec_lat_min,
    output logic [CNT_W-1:0]        rec_lat_max,
    output logic [CNT_W-1:0]        rec_stall,
    output logic                    rec_incomplete,
    output logic                    dump_done
);

    localparam int IDX_W = $clog2(NUM_CH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    top_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              rec_valid_q;
    logic              dump_done_q;
    logic              freeze;
    ch_stats_t         stats [NUM_CH];
    logic [NUM_CH-1:0] busy;
    ch_stats_t         sel;
    logic              sel_busy;
    logic              unused_obs;

    assign freeze = (state_q != TOP_MON);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ap_ch_tracker #(.CNT_W(CNT_W)) u_trk (
            .clock        (clock),
            .reset        (reset),
            .freeze_i     (freeze),
            .ap_start_i   (ap_start[g]),
            .ap_done_i    (ap_done[g]),
            .ap_continue_i(ap_continue[g]),
            .stats_o      (stats[g]),
            .busy_o       (busy[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= TOP_MON;
            idx_q       <= '0;
            rec_valid_q <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            case (state_q)
                TOP_MON: begin
                    if (finish) begin
                        state_q     <= TOP_DUMP;
                        idx_q       <= '0;
                        rec_valid_q <= 1'b1;
                    end
                end
                TOP_DUMP: begin
                    if (rec_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= TOP_END;
                            idx_q       <= '0;
                            rec_valid_q <= 1'b0;
                            dump_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                TOP_END: ;
                default: state_q <= TOP_MON;
            endcase
        end
    end

    always_comb begin
        sel      = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel      = stats[i];
                sel_busy = busy[i];
            end
        end
    end

    // ap_ready is observe-only; stats bits above CNT_W are always zero
    assign unused_obs = ^{ap_ready, sel};

    assign rec_valid      = rec_valid_q;
    assign dump_done      = dump_done_q;
    assign rec_ch         = idx_q;
    assign rec_count      = sel.count[CNT_W-1:0];
    assign rec_lat_last   = sel.lat_last[CNT_W-1:0];
    assign rec_lat_min    = (sel.count == '0) ? '0 : sel.lat_min[CNT_W-1:0];
    assign rec_lat_max    = sel.lat_max[CNT_W-1:0];
    assign rec_stall      = sel.stall[CNT_W-1:0];
    assign rec_incomplete = rec_valid_q && sel_busy;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench for ap_ctrl_perf_monitor: directed channel traffic with
// hand-computed records queued ahead of each dump, checked by record monitors.
module tb_ap_ctrl_perf_monitor;

    typedef struct packed {
        logic [7:0]  ch;
        logic [31:0] cnt;
        logic [31:0] last;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [31:0] stall;
        logic        inc;
    } rec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        finish, rec_ready;
    logic        rec_valid;
    logic [2:0]  rec_ch;
    logic [31:0] rec_count, rec_lat_last, rec_lat_min, rec_lat_max, rec_stall;
    logic        rec_incomplete, dump_done;

    logic [0:0]  s_start, s_ready, s_done, s_cont;
    logic        s_finish, s_rec_ready;
    logic        s_rec_valid;
    logic [0:0]  s_rec_ch;
    logic [3:0]  s_count, s_last, s_min, s_max, s_stall;
    logic        s_inc, s_dump_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   stall_cycles = 0;
    rec_t q1[$];
    rec_t q2[$];

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_ch(rec_ch),
        .rec_count(rec_count), .rec_lat_last(rec_lat_last), .rec_lat_min(rec_lat_min),
        .rec_lat_max(rec_lat_max), .rec_stall(rec_stall),
        .rec_incomplete(rec_incomplete), .dump_done(dump_done)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(4)) dut_s (
        .clock(clock), .reset(reset),
        .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done), .ap_continue(s_cont),
        .finish(s_finish), .rec_ready(s_rec_ready), .rec_valid(s_rec_valid), .rec_ch(s_rec_ch),
        .rec_count(s_count), .rec_lat_last(s_last), .rec_lat_min(s_min),
        .rec_lat_max(s_max), .rec_stall(s_stall),
        .rec_incomplete(s_inc), .dump_done(s_dump_done)
    );

    function automatic rec_t mk(int ch, int cnt, int last, int mn, int mx, int st, int inc);
        rec_t r;
        r.ch    = 8'(ch);
        r.cnt   = 32'(cnt);
        r.last  = 32'(last);
        r.mn    = 32'(mn);
        r.mx    = 32'(mx);
        r.stall = 32'(st);
        r.inc   = 1'(inc);
        return r;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void cmp_rec(string name, rec_t got, rec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got cnt=%0d last=%0d min=%0d max=%0d stall=%0d inc=%0d ch=%0d, expected cnt=%0d last=%0d min=%0d max=%0d stall=%0d inc=%0d ch=%0d",
                     name, exp.ch, got.cnt, got.last, got.mn, got.mx, got.stall, got.inc, got.ch,
                     exp.cnt, exp.last, exp.mn, exp.mx, exp.stall, exp.inc, exp.ch);
        end
    endfunction

    always @(negedge clock) begin
        rec_t got;
        if (!reset && rec_valid) begin
            got.ch    = 8'(rec_ch);
            got.cnt   = rec_count;
            got.last  = rec_lat_last;
            got.mn    = rec_lat_min;
            got.mx    = rec_lat_max;
            got.stall = rec_stall;
            got.inc   = rec_incomplete;
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rec_unexpected: got record ch%0d with no record expected", rec_ch);
            end else begin
                cmp_rec("rec", got, q1[0]);
                if (rec_ready) void'(q1.pop_front());
                else stall_cycles++;
            end
        end
    end

    always @(negedge clock) begin
        rec_t got;
        if (!reset && s_rec_valid) begin
            got.ch    = 8'(s_rec_ch);
            got.cnt   = 32'(s_count);
            got.last  = 32'(s_last);
            got.mn    = 32'(s_min);
            got.mx    = 32'(s_max);
            got.stall = 32'(s_stall);
            got.inc   = s_inc;
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sat_rec_unexpected: got record with no record expected");
            end else begin
                cmp_rec("sat_rec", got, q2[0]);
                if (s_rec_ready) void'(q2.pop_front());
            end
        end
    end

    task automatic drive_main();
        for (int cyc = 0; cyc < 80; cyc++) begin
            ap_start    = '0;
            ap_done     = '0;
            ap_continue = '0;
            ap_start[0]    = (cyc == 10) || (cyc > 60);
            ap_done[0]     = (cyc == 15) || (cyc > 60);
            ap_continue[0] = (cyc == 15) || (cyc > 60);
            ap_start[1]    = (cyc == 12);
            ap_done[1]     = (cyc >= 20) && (cyc <= 23);
            ap_continue[1] = (cyc == 23);
            ap_start[2]    = (cyc == 30) || (cyc == 32) || (cyc == 39);
            ap_done[2]     = (cyc == 32) || (cyc == 39) || (cyc == 43);
            ap_continue[2] = 1'b1;
            ap_start[3]    = (cyc == 50);
            ap_ready       = ap_start;
            finish         = (cyc == 60) || (cyc == 62) || (cyc == 75);
            rec_ready      = (cyc >= 66);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_small();
        s_rec_ready = 1'b1;
        for (int c = 0; c < 62; c++) begin
            s_start[0]  = (c <= 20);
            s_done[0]   = ((c >= 1) && (c <= 20)) || ((c >= 40) && (c <= 59));
            s_cont[0]   = ((c >= 1) && (c <= 20)) || (c == 60);
            s_ready     = s_start;
            s_finish    = (c == 61);
            @(posedge clock);
            #1;
        end
        s_start = '0; s_done = '0; s_cont = '0; s_finish = 1'b0;
        for (int k = 0; k < 20 && !s_dump_done; k++) begin
            @(posedge clock);
            #1;
        end
        chk("sat_dump_done", 64'(s_dump_done), 1);
        chk("sat_queue_left", 64'(q2.size()), 0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
        finish = 1'b0; rec_ready = 1'b0;
        s_start = '0; s_ready = '0; s_done = '0; s_cont = '0;
        s_finish = 1'b0; s_rec_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rec_valid", 64'(rec_valid), 0);
        chk("rst_dump_done", 64'(dump_done), 0);
        chk("rst_incomplete", 64'(rec_incomplete), 0);
        chk("rst_rec_ch", 64'(rec_ch), 0);
        chk("rst_sat_rec_valid", 64'(s_rec_valid), 0);
        reset = 1'b0;

        q1.push_back(mk(0, 1, 5, 5, 5, 0, 0));
        q1.push_back(mk(1, 1, 11, 11, 11, 3, 0));
        q1.push_back(mk(2, 3, 4, 2, 7, 0, 0));
        q1.push_back(mk(3, 0, 0, 0, 0, 0, 1));
        q2.push_back(mk(0, 15, 15, 1, 15, 15, 0));
        fork
            drive_main();
            drive_small();
        join
        chk("dump_stall_cycles", 64'(stall_cycles), 5);
        chk("dump_queue_left", 64'(q1.size()), 0);
        chk("end_dump_done", 64'(dump_done), 1);
        chk("end_rec_valid", 64'(rec_valid), 0);

        // Mid-dump reset: one short transaction on ch0, then reset while ch2 is presented
        reset = 1'b1;
        ap_start = '0; ap_done = '0; ap_continue = '0; ap_ready = '0;
        finish = 1'b0; rec_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        q1.push_back(mk(0, 1, 3, 3, 3, 0, 0));
        q1.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        q1.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        for (int cyc = 0; cyc < 10; cyc++) begin
            ap_start[0]    = (cyc == 2);
            ap_done[0]     = (cyc == 5);
            ap_continue[0] = (cyc == 5);
            finish         = (cyc == 8);
            rec_ready      = (cyc >= 8);
            @(posedge clock);
            #1;
        end
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rec_valid && rec_ch == 3'd2) begin
                found = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("reach_rec_ch2", 64'(found), 1);
        reset = 1'b1;
        rec_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_rec_valid", 64'(rec_valid), 0);
        chk("midrst_rec_ch", 64'(rec_ch), 0);
        chk("midrst_dump_done", 64'(dump_done), 0);
        chk("midrst_incomplete", 64'(rec_incomplete), 0);
        q1.delete();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk("no_rec_after_reset", 64'(rec_valid), 0);
        end
        for (int c = 0; c < 4; c++) q1.push_back(mk(c, 0, 0, 0, 0, 0, 0));
        finish = 1'b1;
        rec_ready = 1'b1;
        @(posedge clock);
        #1;
        finish = 1'b0;
        for (int k = 0; k < 20 && !dump_done; k++) begin
            @(posedge clock);
            #1;
        end
        chk("post_reset_dump_done", 64'(dump_done), 1);
        chk("post_reset_queue_left", 64'(q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
